eeprom_loader: RTL and testbench
================================

// Module: eeprom_loader
// PURPOSE
//  Boot-time copier between the eeprom SPI reader and the riscv core's memory bus.
//  On start, it reads BYTE_COUNT bytes from EEPROM address 0 upward through the eeprom block's strobe/ready port.
//  It packs the bytes little-endian into 32-bit words and writes them to RAM at LOAD_ADDRESS over the memory_bus write port.
//  It then raises done, which the core uses to leave reset-delay and fetch from 0xc000.
// PARAMETERS
//  BYTE_COUNT      2048      bytes to copy, range 0..2048 (11-bit EEPROM space)
//  LOAD_ADDRESS    16'hc000  RAM byte address of the first word; must be 4-aligned
//  TIMEOUT_CYCLES  65535     max clk cycles allowed per handshake phase before error
// PORTS
//  clk               in   1   CPU clock (divided clock, same as core)
//  reset_n           in   1   asynchronous active-low reset
//  start             in   1   1-cycle pulse; begins a copy when idle
//  eeprom_address    out  11  byte address to eeprom block
//  eeprom_strobe     out  1   read request to eeprom block
//  eeprom_ready      in   1   eeprom block idle/data-valid (raw_clk domain)
//  eeprom_data_out   in   8   byte returned by eeprom block
//  mem_address       out  16  memory_bus byte address
//  mem_write         out  32  memory_bus write data
//  mem_write_mask    out  4   memory_bus lane mask; 0 = write lane (bit n = byte n)
//  mem_bus_enable    out  1   memory_bus enable
//  mem_write_enable  out  1   memory_bus write enable
//  busy              out  1   copy in progress
//  done              out  1   sticky: last copy completed OK
//  error             out  1   sticky: last copy timed out
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - State goes to IDLE; byte_index=0.
//   - All outputs are 0, except mem_write_mask=4'b1111.
//  eeprom_ready passes through a 2-flop synchroniser; all tests below use the synchronised value.
//  States: IDLE, REQ, ACK, CAPTURE, WRITE_0, WRITE_1, DONE, ERROR.
//  IDLE:
//   - start=1 clears done/error, sets busy, byte_index=0, word buffer=0, lane mask=4'b1111.
//   - Next state is REQ, or DONE if BYTE_COUNT==0.
//   - start is ignored in every state except IDLE, DONE and ERROR.
//  REQ: eeprom_address=byte_index; eeprom_strobe=1; wait for ready=0 -> ACK.
//  ACK: eeprom_strobe=0; wait for ready=1 -> CAPTURE.
//   - 4-phase handshake, so it is safe across the raw_clk/clk boundary.
//  CAPTURE:
//   - Byte goes to lane byte_index[1:0] of the word buffer; that lane's mask bit is cleared.
//   - Then byte_index++.
//   - If the lane was 3 or byte_index reached BYTE_COUNT -> WRITE_0; else -> REQ.
//  WRITE_0:
//   - mem_address = LOAD_ADDRESS + {(byte_index-1)[10:2],2'b00}.
//   - mem_write = buffer; mem_write_mask = lane mask.
//   - mem_bus_enable=1, mem_write_enable=1 for exactly this one cycle.
//  WRITE_1:
//   - Deassert enables; clear buffer to 0 and mask to 4'b1111.
//   - -> REQ, or DONE if byte_index==BYTE_COUNT.
//  A partial final word (BYTE_COUNT%4 != 0) is written with the unfilled lanes masked (mask bit=1).
//  DONE: busy=0, done=1; start restarts a copy.
//  Timeout:
//   - Per-phase counter resets on entry to REQ and to ACK.
//   - If it reaches TIMEOUT_CYCLES -> ERROR: strobe=0, busy=0, error=1.
//   - start restarts a copy.
//  Reset mid-copy aborts immediately with no further bus write; RAM contents are left as-is.
//  Throughput: 1 bus write per 4 bytes; fixed overhead of 2 cycles per word write.
// TESTING
//  1. BYTE_COUNT=8, EEPROM 01..08:
//     - writes 0x04030201 @c000 and then 0x08070605 @c004, each with mask 0000 and a 1-cycle enable;
//     - then done=1, busy=0.
//  2. BYTE_COUNT=6, EEPROM AA..AF: 2nd write is 0x0000AFAE @c004 with mask 1100.
//  3. BYTE_COUNT=0, start: done=1 within 2 cycles; no strobe and no bus enable.
//  4. Model holds ready=1 forever after a strobe: after TIMEOUT_CYCLES -> error=1, busy=0, strobe=0.
//  5. reset_n low during byte 5 of 8:
//     - all outputs are 0 and mask=1111 immediately;
//     - no write to c004;
//     - a new start recopies from address 0.
//  6. start pulsed again while busy: ignored; exactly BYTE_COUNT/4 writes occur.

Source files
------------

// File: rtl/eeprom_loader_if.sv
// Bus bundle between the boot loader, the EEPROM reader port and the memory_bus write port.
interface eeprom_loader_if;
   logic [10:0] eeprom_address;
   logic        eeprom_strobe;
   logic        eeprom_ready;
   logic [7:0]  eeprom_data_out;
   logic [15:0] mem_address;
   logic [31:0] mem_write;
   logic [3:0]  mem_write_mask;
   logic        mem_bus_enable;
   logic        mem_write_enable;

   modport master (
      output eeprom_address, eeprom_strobe,
      input  eeprom_ready, eeprom_data_out,
      output mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
   );

   modport slave (
      input  eeprom_address, eeprom_strobe,
      output eeprom_ready, eeprom_data_out,
      input  mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
   );
endinterface

// File: rtl/eeprom_loader.sv
// Boot-time copier: reads BYTE_COUNT EEPROM bytes, packs them little-endian into words
// and writes them to RAM at LOAD_ADDRESS, then raises a sticky done (or error on timeout).
module eeprom_loader #(
   parameter int          BYTE_COUNT     = 2048,
   parameter logic [15:0] LOAD_ADDRESS   = 16'hc000,
   parameter int          TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic busy,
   output logic done,
   output logic error,
   eeprom_loader_if.master bus
);
   localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [11:0] BC      = 12'(BYTE_COUNT);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_REQ     = 3'd1;
   localparam logic [2:0] ST_ACK     = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_WRITE_0 = 3'd4;
   localparam logic [2:0] ST_WRITE_1 = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;
   localparam logic [2:0] ST_ERROR   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [11:0]   idx_q, idx_d;
   logic [31:0]   buf_q, buf_d;
   logic [3:0]    mask_q, mask_d;
   logic [8:0]    word_q, word_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          ready_meta_q, ready_sync_q;
   logic [11:0]   idx_inc;
   logic [1:0]    lane;
   logic          wr_cycle;

   assign idx_inc  = idx_q + 12'd1;
   assign lane     = idx_q[1:0];
   assign wr_cycle = (state_q == ST_WRITE_0);

   // eeprom_ready comes from the raw_clk domain; sync resets to idle-high so a
   // start straight after reset still waits for a real ready drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_meta_q <= 1'b1;
         ready_sync_q <= 1'b1;
      end else begin
         ready_meta_q <= bus.eeprom_ready;
         ready_sync_q <= ready_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      mask_d  = mask_q;
      word_d  = word_q;
      tmo_d   = tmo_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               idx_d   = '0;
               buf_d   = '0;
               mask_d  = 4'b1111;
               tmo_d   = '0;
               if (BC == 12'd0) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_REQ;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (!ready_sync_q) begin
               state_d = ST_ACK;
               tmo_d   = '0;
            end else if (tmo_q == TMO_MAX) begin
               state_d = ST_ERROR;
               busy_d  = 1'b0;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_ACK: begin
            if (ready_sync_q) begin
               state_d = ST_CAPTURE;
            end else if (tmo_q == TMO_MAX) begin
               state_d = ST_ERROR;
               busy_d  = 1'b0;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_CAPTURE: begin
            buf_d[8*lane +: 8] = bus.eeprom_data_out;
            mask_d[lane]       = 1'b0;
            idx_d              = idx_inc;
            word_d             = idx_q[10:2];
            if (lane == 2'd3 || idx_inc == BC) begin
               state_d = ST_WRITE_0;
            end else begin
               state_d = ST_REQ;
               tmo_d   = '0;
            end
         end
         ST_WRITE_0: state_d = ST_WRITE_1;
         ST_WRITE_1: begin
            buf_d  = '0;
            mask_d = 4'b1111;
            if (idx_q == BC) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ST_REQ;
               tmo_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         mask_q  <= 4'b1111;
         word_q  <= '0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         mask_q  <= mask_d;
         word_q  <= word_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign error = error_q;

   // Bus outputs are decoded from state so reset forces them idle without a clock edge.
   assign bus.eeprom_strobe    = (state_q == ST_REQ);
   assign bus.eeprom_address   = (state_q == ST_REQ) ? idx_q[10:0] : 11'd0;
   assign bus.mem_bus_enable   = wr_cycle;
   assign bus.mem_write_enable = wr_cycle;
   assign bus.mem_address      = wr_cycle ? (LOAD_ADDRESS + {5'd0, word_q, 2'b00}) : 16'd0;
   assign bus.mem_write        = wr_cycle ? buf_q : 32'd0;
   assign bus.mem_write_mask   = wr_cycle ? mask_q : 4'b1111;
endmodule

// File: tb/tb_eeprom_loader.sv
// Scoreboard bench: three loader instances (8, 6 and 0 bytes) against a simple EEPROM handshake model.
module tb_eeprom_loader;
   localparam int TMO = 40;

   typedef struct {
      int          inst;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic busy_w [3];
   logic done_w [3];
   logic error_w [3];

   logic        strobe_w [3];
   logic [10:0] addr_w [3];
   logic        en_w [3];
   logic        we_w [3];
   logic [15:0] maddr_w [3];
   logic [31:0] mdata_w [3];
   logic [3:0]  mask_w [3];
   logic        rdy [3] = '{1'b1, 1'b1, 1'b1};
   logic [7:0]  dat [3] = '{8'h00, 8'h00, 8'h00};
   logic        hang [3] = '{1'b0, 1'b0, 1'b0};

   int  wr_cnt [3] = '{0, 0, 0};
   int  str_cnt [3] = '{0, 0, 0};
   wr_t exp_q [$];
   int  n_checks = 0;
   int  n_fails  = 0;

   always #5 clk = ~clk;

   eeprom_loader_if bus0 ();
   eeprom_loader_if bus1 ();
   eeprom_loader_if bus2 ();

   eeprom_loader #(.BYTE_COUNT(8), .LOAD_ADDRESS(16'hc000), .TIMEOUT_CYCLES(TMO)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]), .bus(bus0.master));
   eeprom_loader #(.BYTE_COUNT(6), .LOAD_ADDRESS(16'hc000), .TIMEOUT_CYCLES(TMO)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]), .bus(bus1.master));
   eeprom_loader #(.BYTE_COUNT(0), .LOAD_ADDRESS(16'hc000), .TIMEOUT_CYCLES(TMO)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2),
      .busy(busy_w[2]), .done(done_w[2]), .error(error_w[2]), .bus(bus2.master));

   assign strobe_w[0] = bus0.eeprom_strobe;  assign addr_w[0]  = bus0.eeprom_address;
   assign en_w[0]     = bus0.mem_bus_enable; assign we_w[0]    = bus0.mem_write_enable;
   assign maddr_w[0]  = bus0.mem_address;    assign mdata_w[0] = bus0.mem_write;
   assign mask_w[0]   = bus0.mem_write_mask;
   assign bus0.eeprom_ready = rdy[0];        assign bus0.eeprom_data_out = dat[0];
   assign strobe_w[1] = bus1.eeprom_strobe;  assign addr_w[1]  = bus1.eeprom_address;
   assign en_w[1]     = bus1.mem_bus_enable; assign we_w[1]    = bus1.mem_write_enable;
   assign maddr_w[1]  = bus1.mem_address;    assign mdata_w[1] = bus1.mem_write;
   assign mask_w[1]   = bus1.mem_write_mask;
   assign bus1.eeprom_ready = rdy[1];        assign bus1.eeprom_data_out = dat[1];
   assign strobe_w[2] = bus2.eeprom_strobe;  assign addr_w[2]  = bus2.eeprom_address;
   assign en_w[2]     = bus2.mem_bus_enable; assign we_w[2]    = bus2.mem_write_enable;
   assign maddr_w[2]  = bus2.mem_address;    assign mdata_w[2] = bus2.mem_write;
   assign mask_w[2]   = bus2.mem_write_mask;
   assign bus2.eeprom_ready = rdy[2];        assign bus2.eeprom_data_out = dat[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // EEPROM model: 4-phase strobe/ready; instance 0 returns addr+1, instance 1 returns AA+addr.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (hang[k]) begin
            rdy[k] <= 1'b1;
         end else if (strobe_w[k] && rdy[k]) begin
            rdy[k] <= 1'b0;
            dat[k] <= (k == 1) ? 8'(8'hAA + addr_w[k][7:0]) : 8'(addr_w[k][7:0] + 8'd1);
         end else if (!strobe_w[k] && !rdy[k]) begin
            rdy[k] <= 1'b1;
         end
      end
   end

   // Write monitor: every enabled bus cycle pops the scoreboard.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (strobe_w[k]) str_cnt[k]++;
         if (en_w[k]) begin
            wr_t e;
            wr_cnt[k]++;
            check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("wr_inst", k, e.inst);
               check_eq("wr_addr", 32'(maddr_w[k]), 32'(e.addr));
               check_eq("wr_data", mdata_w[k], e.data);
               check_eq("wr_mask", 32'(mask_w[k]), 32'(e.mask));
               check_eq("wr_we", 32'(we_w[k]), 32'd1);
            end
            $display("write inst=%0d addr=%h data=%h mask=%b", k, maddr_w[k], mdata_w[k], mask_w[k]);
         end
      end
   end

   task automatic push_wr(input int k, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
      wr_t e;
      e.inst = k; e.addr = a; e.data = d; e.mask = m;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk);
      if (k == 0) start0 = 1'b1; else if (k == 1) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_end(input int k, input int budget, output int cycles);
      cycles = 0;
      while (!done_w[k] && !error_w[k] && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check_eq("end_in_budget", 32'(done_w[k] || error_w[k]), 32'd1);
   endtask

   initial begin
      int cyc;
      int base;
      #1;
      check_eq("rst_busy", 32'(busy_w[0]), 32'd0);
      check_eq("rst_done", 32'(done_w[0]), 32'd0);
      check_eq("rst_error", 32'(error_w[0]), 32'd0);
      check_eq("rst_strobe", 32'(strobe_w[0]), 32'd0);
      check_eq("rst_en", 32'(en_w[0]), 32'd0);
      check_eq("rst_mask", 32'(mask_w[0]), 32'hf);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 8 bytes 01..08
      push_wr(0, 16'hc000, 32'h04030201, 4'b0000);
      push_wr(0, 16'hc004, 32'h08070605, 4'b0000);
      base = wr_cnt[0];
      pulse_start(0);
      wait_end(0, 500, cyc);
      check_eq("t1_done", 32'(done_w[0]), 32'd1);
      check_eq("t1_busy", 32'(busy_w[0]), 32'd0);
      check_eq("t1_writes", 32'(wr_cnt[0] - base), 32'd2);
      check_eq("t1_queue", 32'(exp_q.size()), 32'd0);
      $display("test1 done in %0d cycles", cyc);

      // 6 bytes AA..AF, partial last word
      push_wr(1, 16'hc000, 32'hADACABAA, 4'b0000);
      push_wr(1, 16'hc004, 32'h0000AFAE, 4'b1100);
      pulse_start(1);
      wait_end(1, 500, cyc);
      check_eq("t2_done", 32'(done_w[1]), 32'd1);
      check_eq("t2_queue", 32'(exp_q.size()), 32'd0);
      $display("test2 done in %0d cycles", cyc);

      // zero bytes
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
      check_eq("t3_done", 32'(done_w[2]), 32'd1);
      check_eq("t3_strobes", 32'(str_cnt[2]), 32'd0);
      check_eq("t3_writes", 32'(wr_cnt[2]), 32'd0);
      $display("test3 done=%0d", done_w[2]);

      // timeout: ready never drops
      hang[0] = 1'b1;
      pulse_start(0);
      cyc = 0;
      while (!strobe_w[0] && cyc < 20) begin @(negedge clk); cyc++; end
      check_eq("t4_strobe_seen", 32'(strobe_w[0]), 32'd1);
      cyc = 0;
      while (!error_w[0] && cyc < 200) begin @(negedge clk); cyc++; end
      check_eq("t4_error", 32'(error_w[0]), 32'd1);
      check_eq("t4_tmo_range", 32'(cyc >= TMO && cyc <= TMO + 4), 32'd1);
      check_eq("t4_busy", 32'(busy_w[0]), 32'd0);
      check_eq("t4_strobe", 32'(strobe_w[0]), 32'd0);
      $display("test4 error after %0d cycles", cyc);
      hang[0] = 1'b0;
      repeat (3) @(negedge clk);

      // start pulsed again while busy
      push_wr(0, 16'hc000, 32'h04030201, 4'b0000);
      push_wr(0, 16'hc004, 32'h08070605, 4'b0000);
      base = wr_cnt[0];
      pulse_start(0);
      check_eq("t6_err_clr", 32'(error_w[0]), 32'd0);
      repeat (10) @(negedge clk);
      check_eq("t6_busy", 32'(busy_w[0]), 32'd1);
      pulse_start(0);
      wait_end(0, 500, cyc);
      repeat (5) @(negedge clk);
      check_eq("t6_writes", 32'(wr_cnt[0] - base), 32'd2);
      check_eq("t6_done", 32'(done_w[0]), 32'd1);
      $display("test6 writes=%0d", wr_cnt[0] - base);

      // reset during byte 5
      push_wr(0, 16'hc000, 32'h04030201, 4'b0000);
      base = wr_cnt[0];
      pulse_start(0);
      cyc = 0;
      while (!(strobe_w[0] && addr_w[0] == 11'd4) && cyc < 500) begin @(negedge clk); cyc++; end
      check_eq("t5_byte5", 32'(addr_w[0]), 32'd4);
      reset_n = 1'b0;
      #1;
      check_eq("t5_busy", 32'(busy_w[0]), 32'd0);
      check_eq("t5_done", 32'(done_w[0]), 32'd0);
      check_eq("t5_strobe", 32'(strobe_w[0]), 32'd0);
      check_eq("t5_eaddr", 32'(addr_w[0]), 32'd0);
      check_eq("t5_en", 32'(en_w[0]), 32'd0);
      check_eq("t5_mask", 32'(mask_w[0]), 32'hf);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("t5_writes", 32'(wr_cnt[0] - base), 32'd1);
      check_eq("t5_queue", 32'(exp_q.size()), 32'd0);
      push_wr(0, 16'hc000, 32'h04030201, 4'b0000);
      push_wr(0, 16'hc004, 32'h08070605, 4'b0000);
      pulse_start(0);
      cyc = 0;
      while (!strobe_w[0] && cyc < 20) begin @(negedge clk); cyc++; end
      check_eq("t5_restart_addr", 32'(addr_w[0]), 32'd0);
      wait_end(0, 500, cyc);
      check_eq("t5_redone", 32'(done_w[0]), 32'd1);
      check_eq("t5_requeue", 32'(exp_q.size()), 32'd0);
      $display("test5 recopy done in %0d cycles", cyc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
